// File: rtl/boron_pkg.sv
// Shared definitions for the Boron decryption datapath.
package boron_pkg;

    // Nibbles per 64-bit Boron state.
    localparam int unsigned BORON_NIBBLES = 16;

    // Inverse S-box, indexed by the substituted nibble value.
    localparam logic [3:0] INV_SBOX [16] = '{
        4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
        4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
    };

    // Serial inverse substitution layer control states.
    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StDone
    } inv_sub_state_e;

endpackage

// File: rtl/s_box_decryption.sv
// Combinational 4-bit inverse S-box for the Boron decryption datapath.
module s_box_decryption
    import boron_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [3:0] data_o
);

    // Single table lookup; no pipeline stage.
    always_comb begin
        data_o = INV_SBOX[data_i];
    end

endmodule

// File: rtl/inv_sub_layer_serial.sv
// Nibble-serial inverse substitution layer: one S-box, one nibble per cycle.
// The state rotates right by one nibble each SUB cycle with the substituted low
// nibble re-entering at the top, so after NIBBLES cycles every nibble is back in
// place and has passed through the S-box exactly once.
module inv_sub_layer_serial
    import boron_pkg::*;
#(
    parameter int unsigned NIBBLES = BORON_NIBBLES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [4*NIBBLES-1:0]   data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [4*NIBBLES-1:0]   data_o,
    output logic                   busy_o
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NIBBLES - 1);

    inv_sub_state_e  state_q, state_d;
    logic [W-1:0]    st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      sbox_out;

    s_box_decryption u_sbox (
        .data_i (st_q[3:0]),
        .data_o (sbox_out)
    );

    // Next-state logic for the control FSM, working register and nibble counter.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    st_d    = data_i;
                    cnt_d   = '0;
                    state_d = StSub;
                end
            end
            StSub: begin
                // Shift right one nibble, substituted low nibble enters at the top.
                st_d  = W'({sbox_out, st_q} >> 4);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Output and input handshakes may complete on the same edge.
                if (ready_i) begin
                    if (valid_i) begin
                        st_d    = data_i;
                        cnt_d   = '0;
                        state_d = StSub;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any block in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            st_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        busy_o  = (state_q == StSub);
        valid_o = (state_q == StDone);
        data_o  = valid_o ? st_q : '0;
        // Gated by rst_ni so nothing is accepted while reset is held.
        ready_o = rst_ni & ((state_q == StIdle) | ((state_q == StDone) & ready_i));
    end

endmodule

// File: tb/tb_inv_sub_layer_serial.sv
// Self-checking bench for inv_sub_layer_serial: directed cases plus random traffic,
// with a queue-based scoreboard and an independent output monitor.
module tb_inv_sub_layer_serial;

    localparam int N = 16;

    // Reference inverse S-box used by the model.
    localparam logic [3:0] REF_SBOX [16] = '{
        4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
        4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
    };

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pushed = 0;
    int          popped = 0;
    logic [63:0] exp_q[$];
    int          acc_q[$];
    logic [63:0] last_out = '0;
    logic        prev_valid = 1'b0;

    inv_sub_layer_serial #(
        .NIBBLES (N)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every nibble mapped independently through the inverse S-box.
    function automatic logic [63:0] ref_inv_sub(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = REF_SBOX[s[4*i +: 4]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; records expected output when the input handshake fires.
    task automatic drive(input logic v, input logic [63:0] d, input logic r, output bit fired);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        fired = rst_ni && valid_i && ready_o;
        if (fired) begin
            exp_q.push_back(ref_inv_sub(d));
            acc_q.push_back(cyc + 1);
            pushed++;
        end
    endtask

    // Hold valid_i until accepted; returns the index of the accepting edge.
    task automatic send(input logic [63:0] d, input logic r, output int acc);
        bit f;
        f   = 1'b0;
        acc = -1;
        for (int i = 0; i < 200 && !f; i++) begin
            drive(1'b1, d, r, f);
            if (f) acc = cyc + 1;
        end
        if (!f) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance expected acceptance of %h", d);
        end
    endtask

    task automatic idle(input int n, input logic r);
        bit f;
        for (int i = 0; i < n; i++) drive(1'b0, '0, r, f);
    endtask

    // Output monitor: compares every presented result against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni) begin
                prev_valid = 1'b0;
            end else begin
                if (valid_o) begin
                    check("ready_passthru", 64'(ready_o), 64'(ready_i));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected no output", data_o);
                    end else begin
                        check("data_o", data_o, exp_q[0]);
                        if (!prev_valid) check("latency", 64'(cyc - acc_q[0]), 64'(N));
                        if (ready_i) begin
                            last_out = data_o;
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            popped++;
                        end
                    end
                end else begin
                    check("data_o_zero_when_invalid", data_o, 64'h0);
                end
                prev_valid = valid_o;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  a0, a1, blocks;
        bit  f, hold;
        logic v;
        logic [63:0] d;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_o", 64'(valid_o), 64'h0);
        check("rst_data_o", data_o, 64'h0);
        check("rst_busy_o", 64'(busy_o), 64'h0);
        check("rst_ready_o", 64'(ready_o), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("ready_after_reset", 64'(ready_o), 64'h1);

        // All-zero block.
        send(64'h0, 1'b1, a0);
        idle(20, 1'b1);
        check("zero_block", last_out, 64'hAAAA_AAAA_AAAA_AAAA);

        // Counting pattern, then a long output stall with noise on the input side.
        send(64'h0123_4567_89AB_CDEF, 1'b1, a0);
        idle(20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom % 2), {$urandom, $urandom}, 1'b0, f);
        end
        check("stall_data", data_o, 64'hA39E_1DF4_C572_680B);
        check("stall_ready_o", 64'(ready_o), 64'h0);
        check("stall_no_capture", 64'(exp_q.size()), 64'h1);
        idle(3, 1'b1);
        check("count_block", last_out, 64'hA39E_1DF4_C572_680B);
        check("stall_drained", 64'(exp_q.size()), 64'h0);

        // Back-to-back: second block accepted on the output-handshake edge.
        send(64'h0123_4567_89AB_CDEF, 1'b1, a0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, a1);
        check("b2b_period", 64'(a1 - a0), 64'(N + 1));
        idle(20, 1'b1);
        check("ones_block", last_out, 64'hBBBB_BBBB_BBBB_BBBB);

        // Reset in the middle of SUB abandons the block.
        send({$urandom, $urandom}, 1'b1, a0);
        idle(7, 1'b1);
        check("busy_in_sub", 64'(busy_o), 64'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid_o", 64'(valid_o), 64'h0);
        check("midrst_data_o", data_o, 64'h0);
        check("midrst_busy_o", 64'(busy_o), 64'h0);
        check("midrst_ready_o", 64'(ready_o), 64'h0);
        exp_q.delete();
        acc_q.delete();
        pushed = 0;
        popped = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("ready_after_midrst", 64'(ready_o), 64'h1);
        last_out = '0;
        send(64'h0, 1'b1, a0);
        idle(20, 1'b1);
        check("post_rst_block", last_out, 64'hAAAA_AAAA_AAAA_AAAA);

        // Random traffic with stalls on both handshakes; upstream holds until accepted.
        blocks = 0;
        hold   = 1'b0;
        v      = 1'b0;
        d      = '0;
        for (int c = 0; c < 60000 && blocks < 1000; c++) begin
            if (!hold) begin
                v = ($urandom % 4) != 0;
                d = {$urandom, $urandom};
            end
            drive(v, d, ($urandom % 4) != 0, f);
            if (f) blocks++;
            hold = v && !f;
        end
        check("random_blocks_accepted", 64'(blocks), 64'd1000);
        idle(40, 1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        check("pushed_eq_popped", 64'(popped), 64'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
